rf_storage_sb: RTL
==================

// Module: rf_storage_sb
// PURPOSE
//  Architectural register storage plus busy-bit scoreboard for the decode stage.
//  Sits directly upstream of the combinational read-port muxes; its oMem array drives their mem inputs.
//  Takes writebacks from the WB stage and gates instruction issue on RAW/WAW hazards.
//  r0 reads as zero and is never stored or marked busy.
// PARAMETERS
//  ADDR_WIDTH  4   register index width; NUM_WORDS = 2**ADDR_WIDTH; entries 1..NUM_WORDS-1 stored
//  DATA_WIDTH  32  register data width
//  CNT_WIDTH   16  width of the stall performance counter
// PORTS
//  iClk        in   1                              clock, all state on rising edge
//  iRst_n      in   1                              asynchronous active-low reset
//  iIssueValid in   1                              decode presents an instruction
//  iIssueRs1   in   ADDR_WIDTH                     source 1 index
//  iIssueRs2   in   ADDR_WIDTH                     source 2 index
//  iIssueRd    in   ADDR_WIDTH                     destination index
//  iIssueRdWr  in   1                              instruction writes iIssueRd
//  oIssueReady out  1                              no hazard; issue accepted when iIssueValid & oIssueReady
//  iFlush      in   1                              pipeline flush; clears every busy bit
//  iWbValid    in   1                              writeback strobe
//  iWbAddr     in   ADDR_WIDTH                     writeback index
//  iWbData     in   DATA_WIDTH                     writeback data
//  oMem        out  [NUM_WORDS-1:1][DATA_WIDTH]    register contents, unpacked array indexed 1..NUM_WORDS-1
//  oBusy       out  NUM_WORDS-1 ([NUM_WORDS-1:1])  scoreboard busy bits
//  oWbErr      out  1                              sticky: writeback hit a non-busy register
//  oStallCnt   out  CNT_WIDTH                      saturating count of stalled issue cycles
// BEHAVIOUR
//  Reset (async, iRst_n=0): oMem all 0, oBusy all 0, oWbErr 0, oStallCnt 0. All outputs valid immediately.
//  oIssueReady (comb) = !iFlush & !busy[Rs1] & !busy[Rs2] & !(iIssueRdWr & busy[Rd]); busy[0] is 0.
//   It does not depend on iIssueValid, and a same-cycle writeback does not make it ready.
//  Issue accept: if iIssueRdWr and Rd != 0, busy[Rd] is set at the next edge.
//  Writeback: when iWbValid and iWbAddr != 0, mem[iWbAddr] <= iWbData and busy[iWbAddr] <= 0 at the next edge.
//   New data is visible on oMem one cycle after the strobe; no bypass.
//   Write to index 0 is dropped; it has no effect on any state.
//  Same-cycle accept of Rd=X and WB to X: cannot occur because Rd busy blocks ready.
//   If WB clears X while an accept targets X anyway, the set wins (busy[X]=1).
//  iFlush: all busy bits go to 0 at the next edge, and no issue is accepted that cycle.
//   A WB in the same cycle still writes mem.
//   Killed instructions must not write back; this is an upstream guarantee.
//  oWbErr: set at the edge after iWbValid with iWbAddr != 0 and busy[iWbAddr]=0 (not counting a same-cycle flush).
//   Cleared only by reset. The write is still performed.
//  oStallCnt: +1 per cycle with iIssueValid & !oIssueReady; holds at 2**CNT_WIDTH-1 (saturates).
//  Reset mid-operation clears all state asynchronously; pending writebacks are lost.
// STRUCTURE
//  Shared package rf_pkg: NUM_WORDS localparam, reg_idx_t (ADDR_WIDTH), reg_data_t (DATA_WIDTH),
//   function is_r0(idx).
//  Sub-module rf_scoreboard: owns busy bits, set/clear/flush logic, ready computation and oWbErr.
//  Top module: data array (no write enable on entry 0), stall counter, port wiring to rf_scoreboard.
// TESTING
//  1. Reset, then read oMem -> all entries 0, oBusy=0, oIssueReady=1 for any indices.
//  2. Issue Rd=5 wr=1; next cycle issue Rs1=5 -> oIssueReady=0, oStallCnt increments;
//     WB addr=5 data=0xDEADBEEF -> next cycle oMem[5]=0xDEADBEEF, busy[5]=0, ready=1.
//  3. WB addr=0 data=0xFFFFFFFF; issue Rd=0 wr=1 -> no mem change, oBusy stays 0, oWbErr stays 0.
//  4. Issue Rd=3 and Rd=7, assert iFlush with WB addr=3 data=0x12 -> oBusy=0, oMem[3]=0x12, oWbErr=0.
//  5. WB addr=9 while busy[9]=0 -> oWbErr=1 and oMem[9] updated; oWbErr stays 1 until reset.
//  6. CNT_WIDTH=4, hold a stalled issue for 20 cycles -> oStallCnt=15;
//     drop iRst_n mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and helpers for the register file storage and its busy-bit scoreboard.
package rf_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;
  localparam int unsigned NUM_WORDS      = 2 ** DEF_ADDR_WIDTH;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // r0 is hardwired to zero: never stored, never busy.
  function automatic logic is_r0(input int unsigned idx);
    return idx == 0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations, computes issue readiness, flags stray writebacks.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [ADDR_WIDTH-1:0]     issue_rs1,
  input  logic [ADDR_WIDTH-1:0]     issue_rs2,
  input  logic [ADDR_WIDTH-1:0]     issue_rd,
  input  logic                      issue_rd_wr,
  input  logic                      flush,
  input  logic                      wb_valid,
  input  logic [ADDR_WIDTH-1:0]     wb_addr,
  output logic                      issue_ready_c,
  output logic [2**ADDR_WIDTH-1:1]  busy,
  output logic                      wb_err
);

  localparam int unsigned NUM_ENTRIES = 2 ** ADDR_WIDTH;

  logic [NUM_ENTRIES-1:1] busy_q, busy_d;
  logic                   wb_err_q, wb_err_d;
  logic [NUM_ENTRIES-1:0] busy_full;
  logic                   accept;
  logic                   wb_hit;
  logic                   issue_set;

  // Entry 0 reads as never busy so r0 operands never stall.
  assign busy_full = {busy_q, 1'b0};

  // Readiness, then busy update: clear by WB, clear-all by flush, set by accepted issue (set wins).
  always_comb begin
    busy_d        = busy_q;
    wb_err_d      = wb_err_q;
    issue_ready_c = !flush && !busy_full[issue_rs1] && !busy_full[issue_rs2]
                    && !(issue_rd_wr && busy_full[issue_rd]);
    accept        = issue_valid && issue_ready_c;
    wb_hit        = wb_valid && !is_r0(32'(wb_addr));
    issue_set     = accept && issue_rd_wr && !is_r0(32'(issue_rd));

    for (int unsigned i = 1; i < NUM_ENTRIES; i++) begin
      if (wb_hit && (wb_addr == ADDR_WIDTH'(i))) busy_d[i] = 1'b0;
      if (flush) busy_d[i] = 1'b0;
      if (issue_set && (issue_rd == ADDR_WIDTH'(i))) busy_d[i] = 1'b1;
    end

    if (wb_hit && !busy_full[wb_addr]) wb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy   = busy_q;
  assign wb_err = wb_err_q;

endmodule

// File: rtl/rf_storage_sb.sv
// Architectural register storage with busy-bit scoreboard and stall counter for the decode stage.
module rf_storage_sb
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iIssueValid,
  input  logic [ADDR_WIDTH-1:0]     iIssueRs1,
  input  logic [ADDR_WIDTH-1:0]     iIssueRs2,
  input  logic [ADDR_WIDTH-1:0]     iIssueRd,
  input  logic                      iIssueRdWr,
  output logic                      oIssueReady,
  input  logic                      iFlush,
  input  logic                      iWbValid,
  input  logic [ADDR_WIDTH-1:0]     iWbAddr,
  input  logic [DATA_WIDTH-1:0]     iWbData,
  output logic [DATA_WIDTH-1:0]     oMem [2**ADDR_WIDTH-1:1],
  output logic [2**ADDR_WIDTH-1:1]  oBusy,
  output logic                      oWbErr,
  output logic [CNT_WIDTH-1:0]      oStallCnt
);

  localparam int unsigned NUM_ENTRIES = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRIES-1:1];
  logic [DATA_WIDTH-1:0] mem_d [NUM_ENTRIES-1:1];
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  issue_ready_c;

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk           (iClk),
    .rst_n         (iRst_n),
    .issue_valid   (iIssueValid),
    .issue_rs1     (iIssueRs1),
    .issue_rs2     (iIssueRs2),
    .issue_rd      (iIssueRd),
    .issue_rd_wr   (iIssueRdWr),
    .flush         (iFlush),
    .wb_valid      (iWbValid),
    .wb_addr       (iWbAddr),
    .issue_ready_c (issue_ready_c),
    .busy          (oBusy),
    .wb_err        (oWbErr)
  );

  // Writeback port; there is no entry 0, so an r0 write never matches.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 1; i < NUM_ENTRIES; i++) begin
      if (iWbValid && (iWbAddr == ADDR_WIDTH'(i))) mem_d[i] = iWbData;
    end
  end

  // Saturating count of cycles where decode had an instruction but was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (iIssueValid && !issue_ready_c && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int unsigned i = 1; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oMem        = mem_q;
  assign oStallCnt   = stall_cnt_q;
  assign oIssueReady = issue_ready_c;

endmodule
